// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory path: access sizes, controller states, word width.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // Alignment or encoding error for a given size and low address bits.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: little-endian load extract/extend and sub-word store merge.
module dmem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] repl;

    assign shamt   = {addr_lo, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = word;
        mask      = '1;
        repl      = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                mask      = 32'h0000_00FF << shamt;
                repl      = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
                repl      = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        store_word = (word & ~mask) | (repl & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port to a single-port SRAM with
// read-modify-write for sub-word stores and one request in flight.
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);

    logic [2:0]        state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_sgn;
    logic [1:0]        lat_lo;
    logic [WORD_W-1:0] lat_wdata;

    logic              accept;
    logic              req_err;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] store_word;

    assign o_req_ready = (state == ST_IDLE);
    assign o_rsp_valid = (state == ST_RESP);
    assign o_mem_we    = (state == ST_WR);
    assign accept      = i_req_valid & o_req_ready;

    assign req_err = size_fault(i_req_size, i_req_addr[1:0]) ||
                     ((i_req_addr >> (ADDR_WIDTH + 2)) != '0);

    dmem_lane_unit u_lane (
        .size       (lat_size),
        .addr_lo    (lat_lo),
        .sign_ext   (lat_sgn),
        .word       (i_mem_rdata),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            lat_we      <= 1'b0;
            lat_size    <= '0;
            lat_sgn     <= 1'b0;
            lat_lo      <= '0;
            lat_wdata   <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we      <= i_req_we;
                        lat_size    <= i_req_size;
                        lat_sgn     <= i_req_signed;
                        lat_lo      <= i_req_addr[1:0];
                        lat_wdata   <= i_req_wdata;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= req_err;
                        if (req_err) begin
                            state <= ST_RESP;
                        end else begin
                            o_mem_addr <= i_req_addr[ADDR_WIDTH+1:2];
                            // Full-word stores skip the read and write straight away.
                            if (i_req_we && (i_req_size == SZ_WORD)) begin
                                o_mem_wdata <= i_req_wdata;
                                state       <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: state <= ST_RDW;
                ST_RDW: begin
                    if (lat_we) begin
                        o_mem_wdata <= store_word;
                        state       <= ST_WR;
                    end else begin
                        o_rsp_rdata <= load_data;
                        state       <= ST_RESP;
                    end
                end
                ST_WR: state <= ST_RESP;
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural single-port SRAM.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        chk_mem;
        logic [7:0]  midx;
        logic [31:0] mval;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
    } exp_t;

    localparam int NV = 21;
    vec_t tbl [0:NV-1];
    exp_t sb [$];

    dmem_ctrl #(.ADDR_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, write on we, contents cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat,
                                input logic chk_mem, input logic [7:0] midx,
                                input logic [31:0] mval);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat;
        v.chk_mem = chk_mem; v.midx = midx; v.mval = mval;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   lat;
        int   nwe;
        int   we_cyc;
        logic got;
        @(negedge clk);
        chk({tag, " idle_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        rsp_ready  = 1'b1;
        @(posedge clk);
        e.rdata = v.rdata;
        e.err   = v.err;
        e.lat   = v.lat;
        e.nwe   = (v.we && !v.err) ? 1 : 0;
        sb.push_back(e);
        #1;
        // Scramble the request inputs; only the accepted values may matter.
        req_valid  = 1'b0;
        req_we     = ~v.we;
        req_size   = ~v.size;
        req_signed = ~v.sgn;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0; nwe = 0; we_cyc = 0; got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                we_cyc = c;
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (!got) begin
            chk({tag, " rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " rdata"}, rsp_rdata, e.rdata);
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, e.err});
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " we_pulses"}, nwe, e.nwe);
        if (e.nwe == 1) chk({tag, " we_cycle"}, we_cyc, e.lat - 1);
        @(posedge clk);
        #1;
        if (v.chk_mem) chk({tag, " mem"}, mem[v.midx], v.mval);
    endtask

    int nwe_rst;

    initial begin
        tbl[0]  = mk(1, 2'b10, 0, 32'h10,  32'hAABBCCDD, 32'h0,        0, 2, 1, 8'd4,   32'hAABBCCDD);
        tbl[1]  = mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hAABBCCDD, 0, 3, 0, 8'd0,   32'h0);
        tbl[2]  = mk(0, 2'b00, 1, 32'h13,  32'h0,        32'hFFFFFFAA, 0, 3, 0, 8'd0,   32'h0);
        tbl[3]  = mk(0, 2'b00, 0, 32'h13,  32'h0,        32'h000000AA, 0, 3, 0, 8'd0,   32'h0);
        tbl[4]  = mk(0, 2'b01, 1, 32'h10,  32'h0,        32'hFFFFCCDD, 0, 3, 0, 8'd0,   32'h0);
        tbl[5]  = mk(0, 2'b10, 1, 32'h10,  32'h0,        32'hAABBCCDD, 0, 3, 0, 8'd0,   32'h0);
        tbl[6]  = mk(1, 2'b00, 0, 32'h11,  32'h00000011, 32'h0,        0, 4, 1, 8'd4,   32'hAABB11DD);
        tbl[7]  = mk(0, 2'b01, 0, 32'h12,  32'h0,        32'h0000AABB, 0, 3, 0, 8'd0,   32'h0);
        tbl[8]  = mk(1, 2'b10, 0, 32'h10,  32'hAABBCCDD, 32'h0,        0, 2, 1, 8'd4,   32'hAABBCCDD);
        tbl[9]  = mk(1, 2'b01, 0, 32'h12,  32'hDEAD1234, 32'h0,        0, 4, 1, 8'd4,   32'h1234CCDD);
        tbl[10] = mk(0, 2'b00, 1, 32'h11,  32'h0,        32'hFFFFFFCC, 0, 3, 0, 8'd0,   32'h0);
        tbl[11] = mk(0, 2'b01, 0, 32'h11,  32'h0,        32'h0,        1, 1, 0, 8'd0,   32'h0);
        tbl[12] = mk(0, 2'b10, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0, 8'd0,   32'h0);
        tbl[13] = mk(0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1, 1, 0, 8'd0,   32'h0);
        tbl[14] = mk(0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1, 1, 0, 8'd0,   32'h0);
        tbl[15] = mk(1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h0,        1, 1, 1, 8'd0,   32'h0);
        tbl[16] = mk(1, 2'b01, 0, 32'h13,  32'h0000FFFF, 32'h0,        1, 1, 1, 8'd4,   32'h1234CCDD);
        tbl[17] = mk(1, 2'b10, 0, 32'h3FC, 32'h80000001, 32'h0,        0, 2, 1, 8'd255, 32'h80000001);
        tbl[18] = mk(0, 2'b01, 1, 32'h3FE, 32'h0,        32'hFFFF8000, 0, 3, 0, 8'd0,   32'h0);
        tbl[19] = mk(0, 2'b00, 0, 32'h3FC, 32'h0,        32'h00000001, 0, 3, 0, 8'd0,   32'h0);
        tbl[20] = mk(0, 2'b00, 1, 32'h3FF, 32'h0,        32'hFFFFFF80, 0, 3, 0, 8'd0,   32'h0);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst ready",  {31'd0, req_ready}, 32'd1);
        chk("rst rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("rst err",    {31'd0, rsp_err},   32'd0);
        chk("rst we",     {31'd0, mem_we},    32'd0);
        chk("rst maddr",  {24'd0, mem_addr},  32'd0);
        chk("rst mwdata", mem_wdata,          32'd0);
        chk("rst rdata",  rsp_rdata,          32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: response must hold while i_rsp_ready is low.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rvalid", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d rdata", k),  rsp_rdata,          32'h1234CCDD);
            chk($sformatf("bp%0d ready", k),  {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("bp release ready",  {31'd0, req_ready}, 32'd1);

        // Reset during RDW of a byte store: no write, outputs back to reset values.
        nwe_rst = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (mem_we) nwe_rst++;
        end
        rst_n = 1'b0;
        #1;
        chk("arst rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("arst we",     {31'd0, mem_we},    32'd0);
        chk("arst ready",  {31'd0, req_ready}, 32'd1);
        chk("arst maddr",  {24'd0, mem_addr},  32'd0);
        chk("arst mwdata", mem_wdata,          32'd0);
        chk("arst rdata",  rsp_rdata,          32'd0);
        chk("arst err",    {31'd0, rsp_err},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_we) nwe_rst++;
        end
        chk("arst no write", nwe_rst, 0);
        chk("arst mem4", mem[4], 32'h0);
        run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 3, 0, 8'd0, 32'h0), "post_rst lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
